mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle variant of the MIPS processor.
- Sequences one instruction over 3–5 states: fetch, decode, execute, memory, writeback.
- Drives the datapath muxes, write enables and the 3-bit ALU_ctrl code directly.
- Sits between the instruction register (opcode/func_field) and the shared ALU, register file, PC and unified memory; inserts wait states on a memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/alu_func_decoder.sv | 28 ++
 rtl/mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control: opcode and funct
// encodings, ALU control codes, datapath mux codes and FSM state encoding.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU control codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

endpackage

// File: rtl/alu_func_decoder.sv
// Combinational R-type funct decoder: maps func_field to the ALU control code
// and flags whether the funct is one the datapath supports.
module alu_func_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func_field_i,
  output logic [2:0] alu_ctrl_o,
  output logic       func_valid_o
);

  // Decode funct; unsupported codes fall back to add and are flagged invalid.
  always_comb begin
    alu_ctrl_o   = AluAdd;
    func_valid_o = 1'b1;
    case (func_field_i)
      FnAdd:   alu_ctrl_o = AluAdd;
      FnSub:   alu_ctrl_o = AluSub;
      FnAnd:   alu_ctrl_o = AluAnd;
      FnOr:    alu_ctrl_o = AluOr;
      FnSlt:   alu_ctrl_o = AluSlt;
      default: begin
        alu_ctrl_o   = AluAdd;
        func_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS. Moore-style decode of datapath
// controls from the current state, with mem_ready-qualified enables in the
// memory states and a zero-qualified PC write for beq.
// Optional build macro ILLEGAL_OP_TRAP_EN: illegal opcodes park the FSM in a
// TRAP state until reset; without it they retire as a NOP.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [1:0]  RESET_VECTOR_SEL = 2'b00,
  parameter int unsigned MAX_WAIT         = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_field_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_ctrl_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       retire_o,
  output logic       mem_timeout_o
);

  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       func_ok_q, func_ok_d;

  logic [2:0] fn_alu_ctrl;
  logic       fn_valid;
  logic       waiting;

  alu_func_decoder u_alu_func_decoder (
    .func_field_i (func_field_i),
    .alu_ctrl_o   (fn_alu_ctrl),
    .func_valid_o (fn_valid)
  );

  // A cycle counts as a wait state when a memory access is pending but not ready.
  assign waiting = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
                   !mem_ready_i;

  // Saturating wait counter and sticky timeout flag.
  always_comb begin
    wait_cnt_d = 4'd0;
    timeout_d  = timeout_q;
    if (waiting) begin
      if (wait_cnt_q == MaxWaitCnt) begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  // State, wait counter, timeout flag and latched funct validity.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StFetch;
      wait_cnt_q <= 4'd0;
      timeout_q  <= 1'b0;
      func_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      func_ok_q  <= func_ok_d;
    end
  end

  // Next-state and datapath control decode; reset overrides every output.
  always_comb begin
    state_d      = state_q;
    func_ok_d    = func_ok_q;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SrcBReg;
    alu_ctrl_o   = AluAnd;
    pc_write_o   = 1'b0;
    pc_src_o     = PcSrcAlu;
    retire_o     = 1'b0;

    case (state_q)
      StFetch: begin
        // PC + 4 is computed while the instruction is read.
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        alu_ctrl_o  = AluAdd;
        pc_src_o    = PcSrcAlu;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        // Speculative branch target into ALUOut.
        alu_src_b_o = SrcBImmSh2;
        alu_ctrl_o  = AluAdd;
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = StTrap;
`else
            state_d  = StFetch;
            retire_o = 1'b1;
`endif
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        alu_ctrl_o  = AluAdd;
        state_d     = (opcode_i == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = StFetch;
        end
      end
      StRtypeEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBReg;
        alu_ctrl_o  = fn_alu_ctrl;
        func_ok_d   = fn_valid;
        state_d     = StRtypeWb;
      end
      StRtypeWb: begin
        reg_write_o = func_ok_q;
        reg_dst_o   = 1'b1;
        retire_o    = 1'b1;
        state_d     = StFetch;
      end
      StBeqEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBReg;
        alu_ctrl_o  = AluSub;
        pc_src_o    = PcSrcAluOut;
        pc_write_o  = zero_i;
        retire_o    = 1'b1;
        state_d     = StFetch;
      end
      StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        alu_ctrl_o  = AluAdd;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = StFetch;
      end
      StJump: begin
        pc_src_o   = PcSrcJump;
        pc_write_o = 1'b1;
        retire_o   = 1'b1;
        state_d    = StFetch;
      end
      StTrap: begin
        // Parked with all enables low until reset.
        state_d = StTrap;
      end
      default: state_d = StFetch;
    endcase

    if (reset_i) begin
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_ctrl_o   = 3'b000;
      pc_write_o   = 1'b0;
      pc_src_o     = RESET_VECTOR_SEL;
      retire_o     = 1'b0;
    end
  end

  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Inputs change and outputs are
// sampled around the falling clock edge; each cycle's full control vector is
// compared with a hand-written constant.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] func_field;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, pc_write, retire, mem_timeout;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .opcode_i      (opcode),
    .func_field_i  (func_field),
    .zero_i        (zero),
    .mem_ready_i   (mem_ready),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .iord_o        (iord),
    .ir_write_o    (ir_write),
    .reg_write_o   (reg_write),
    .reg_dst_o     (reg_dst),
    .mem_to_reg_o  (mem_to_reg),
    .alu_src_a_o   (alu_src_a),
    .alu_src_b_o   (alu_src_b),
    .alu_ctrl_o    (alu_ctrl),
    .pc_write_o    (pc_write),
    .pc_src_o      (pc_src),
    .retire_o      (retire),
    .mem_timeout_o (mem_timeout)
  );

  // Field order: mr mw iord irw rw rdst m2r asa asb alu pcw pcs ret
  logic [16:0] obs;
  assign obs = {mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_ctrl, pc_write, pc_src, retire};

  localparam logic [16:0] VRst      = 17'b0_0_0_0_0_0_0_0_00_000_0_00_0;
  localparam logic [16:0] VFetchR   = 17'b1_0_0_1_0_0_0_0_01_010_1_00_0;
  localparam logic [16:0] VFetchW   = 17'b1_0_0_0_0_0_0_0_01_010_0_00_0;
  localparam logic [16:0] VDec      = 17'b0_0_0_0_0_0_0_0_11_010_0_00_0;
  localparam logic [16:0] VDecNop   = 17'b0_0_0_0_0_0_0_0_11_010_0_00_1;
  localparam logic [16:0] VMemAdr   = 17'b0_0_0_0_0_0_0_1_10_010_0_00_0;
  localparam logic [16:0] VMemRd    = 17'b1_0_1_0_0_0_0_0_00_000_0_00_0;
  localparam logic [16:0] VMemWb    = 17'b0_0_0_0_1_0_1_0_00_000_0_00_1;
  localparam logic [16:0] VMemWrW   = 17'b0_1_1_0_0_0_0_0_00_000_0_00_0;
  localparam logic [16:0] VMemWrR   = 17'b0_1_1_0_0_0_0_0_00_000_0_00_1;
  localparam logic [16:0] VRtypeWb  = 17'b0_0_0_0_1_1_0_0_00_000_0_00_1;
  localparam logic [16:0] VRtypeBad = 17'b0_0_0_0_0_1_0_0_00_000_0_00_1;
  localparam logic [16:0] VBeqZ1    = 17'b0_0_0_0_0_0_0_1_00_110_1_01_1;
  localparam logic [16:0] VBeqZ0    = 17'b0_0_0_0_0_0_0_1_00_110_0_01_1;
  localparam logic [16:0] VAddiEx   = 17'b0_0_0_0_0_0_0_1_10_010_0_00_0;
  localparam logic [16:0] VAddiWb   = 17'b0_0_0_0_1_0_0_0_00_000_0_00_1;
  localparam logic [16:0] VJump     = 17'b0_0_0_0_0_0_0_0_00_000_1_10_1;
  localparam logic [16:0] VExAdd    = 17'b0_0_0_0_0_0_0_1_00_010_0_00_0;
  localparam logic [16:0] VExSub    = 17'b0_0_0_0_0_0_0_1_00_110_0_00_0;
  localparam logic [16:0] VExAnd    = 17'b0_0_0_0_0_0_0_1_00_000_0_00_0;
  localparam logic [16:0] VExOr     = 17'b0_0_0_0_0_0_0_1_00_001_0_00_0;
  localparam logic [16:0] VExSlt    = 17'b0_0_0_0_0_0_0_1_00_111_0_00_0;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Compare this cycle's controls, then advance to the next falling edge.
  task automatic step(input string tag, input logic [16:0] want);
    #1;
    chk(tag, obs, want);
    @(negedge clk);
  endtask

  task automatic chk_timeout(input string tag, input logic want);
    chk(tag, {16'd0, mem_timeout}, {16'd0, want});
  endtask

  task automatic rtype(input logic [5:0] f, input logic [16:0] ex_v, input logic [16:0] wb_v);
    opcode     = 6'b000000;
    func_field = f;
    step("rt_fetch", VFetchR);
    step("rt_decode", VDec);
    step("rt_ex", ex_v);
    step("rt_wb", wb_v);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_outputs", obs, VRst);
    chk_timeout("rst_timeout", 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    opcode     = 6'b000000;
    func_field = 6'b100000;
    zero       = 1'b0;
    mem_ready  = 1'b1;
    #1;
    chk("reset_outputs", obs, VRst);
    chk_timeout("reset_timeout", 1'b0);
    @(negedge clk);
    #1;
    chk("reset_held", obs, VRst);
    @(negedge clk);
    reset = 1'b0;

    // add, no wait states: retire on the 4th cycle
    rtype(6'b100000, VExAdd, VRtypeWb);

    // lw with three wait states in MEMRD: 8 cycles total
    opcode = 6'b100011;
    step("lw_fetch", VFetchR);
    step("lw_decode", VDec);
    step("lw_memadr", VMemAdr);
    mem_ready = 1'b0;
    step("lw_memrd_w1", VMemRd);
    step("lw_memrd_w2", VMemRd);
    step("lw_memrd_w3", VMemRd);
    mem_ready = 1'b1;
    step("lw_memrd_rdy", VMemRd);
    step("lw_memwb", VMemWb);
    chk_timeout("lw_timeout", 1'b0);

    // sw, no wait states: 4 cycles
    opcode = 6'b101011;
    step("sw_fetch", VFetchR);
    step("sw_decode", VDec);
    step("sw_memadr", VMemAdr);
    step("sw_memwr", VMemWrR);

    // beq taken and not taken
    opcode = 6'b000100;
    zero   = 1'b1;
    step("beq1_fetch", VFetchR);
    step("beq1_decode", VDec);
    step("beq1_ex", VBeqZ1);
    zero = 1'b0;
    step("beq0_fetch", VFetchR);
    step("beq0_decode", VDec);
    step("beq0_ex", VBeqZ0);

    // funct sweep; 000000 is unsupported and must not write back
    rtype(6'b100010, VExSub, VRtypeWb);
    rtype(6'b100100, VExAnd, VRtypeWb);
    rtype(6'b100101, VExOr, VRtypeWb);
    rtype(6'b101010, VExSlt, VRtypeWb);
    rtype(6'b000000, VExAdd, VRtypeBad);

    // addi and j
    opcode = 6'b001000;
    step("addi_fetch", VFetchR);
    step("addi_decode", VDec);
    step("addi_ex", VAddiEx);
    step("addi_wb", VAddiWb);
    opcode = 6'b000010;
    step("j_fetch", VFetchR);
    step("j_decode", VDec);
    step("j_jump", VJump);

    // illegal opcode
    opcode = 6'b111111;
    step("ill_fetch", VFetchR);
`ifdef ILLEGAL_OP_TRAP_EN
    step("ill_decode", VDec);
    step("ill_trap1", VRst);
    step("ill_trap2", VRst);
    step("ill_trap3", VRst);
`else
    step("ill_decode_nop", VDecNop);
    opcode = 6'b000000;
    step("ill_next_fetch", VFetchR);
`endif
    pulse_reset();

    // FETCH wait limit: 15 wait cycles are tolerated, the 16th flags timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("to_fetch_wait", VFetchW);
    chk_timeout("to_after15", 1'b0);
    step("to_fetch_wait16", VFetchW);
    chk_timeout("to_after16", 1'b1);
    mem_ready = 1'b1;
    opcode    = 6'b101011;
    step("to_fetch_rdy", VFetchR);
    chk_timeout("to_sticky", 1'b1);

    // reset asserted while MEMWR waits
    step("rs_decode", VDec);
    step("rs_memadr", VMemAdr);
    mem_ready = 1'b0;
    step("rs_memwr_w", VMemWrW);
    pulse_reset();
    step("rs_fetch_w1", VFetchW);
    step("rs_fetch_w2", VFetchW);
    mem_ready = 1'b1;
    step("rs_fetch_rdy", VFetchR);
    step("rs_decode2", VDec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
